// File: rtl/seq_responder.sv
// Detects C, then 1..BMAX consecutive B, then A, and answers with JLEN cycles of J then one K.
// Optional drop counter enabled by SEQ_RESPONDER_DROP_CNT_EN.
module seq_responder #(
  parameter int JLEN = 4,
  parameter int BMAX = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       C,
  input  logic       B,
  input  logic       A,
  input  logic       X,
  output logic       J,
  output logic       K,
  output logic       BUSY,
  output logic [7:0] DROP_CNT
);

  typedef enum logic [1:0] {
    IDLE,
    RESP_J,
    RESP_K
  } state_t;

  localparam logic [3:0] JLOAD = 4'(JLEN - 1);

  state_t      r_state;
  state_t      w_state_d;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_d;
  logic        r_j;
  logic        r_k;
  logic        r_busy;
  logic        w_j_d;
  logic        w_k_d;
  logic        w_busy_d;

  // r_c_hist[i] holds C from i+1 cycles ago; r_b_hist[i] holds B from i+1 cycles ago.
  logic [BMAX:0]   r_c_hist;
  logic [BMAX-1:0] r_b_hist;
  logic            w_match;
  logic            w_detect;

  always_comb begin
    logic v_run;
    w_match = 1'b0;
    v_run   = 1'b1;
    for (int k = 1; k <= BMAX; k++) begin
      v_run = v_run & r_b_hist[k-1];
      if (v_run && r_c_hist[k]) begin
        w_match = 1'b1;
      end
    end
  end

  assign w_detect = A & ~X & w_match;

  always_ff @(posedge CLK) begin
    if (RST || X) begin
      r_c_hist <= '0;
      r_b_hist <= '0;
    end else begin
      r_c_hist[0] <= C;
      r_b_hist[0] <= B;
      for (int i = 1; i <= BMAX; i++) begin
        r_c_hist[i] <= r_c_hist[i-1];
      end
      for (int i = 1; i < BMAX; i++) begin
        r_b_hist[i] <= r_b_hist[i-1];
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    if (X) begin
      w_state_d = IDLE;
      w_cnt_d   = 4'd0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_detect) begin
            w_state_d = RESP_J;
            w_cnt_d   = JLOAD;
          end
        end
        RESP_J: begin
          if (r_cnt == 4'd0) begin
            w_state_d = RESP_K;
          end else begin
            w_cnt_d = r_cnt - 4'd1;
          end
        end
        RESP_K: begin
          w_state_d = IDLE;
        end
        default: begin
          w_state_d = IDLE;
          w_cnt_d   = 4'd0;
        end
      endcase
    end
    w_j_d    = (w_state_d == RESP_J);
    w_k_d    = (w_state_d == RESP_K);
    w_busy_d = w_j_d | w_k_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_j     <= 1'b0;
      r_k     <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_j     <= w_j_d;
      r_k     <= w_k_d;
      r_busy  <= w_busy_d;
    end
  end

  assign J    = r_j;
  assign K    = r_k;
  assign BUSY = r_busy;

`ifdef SEQ_RESPONDER_DROP_CNT_EN
  logic [7:0] r_drop_cnt;
  logic       w_drop;

  // A detection while already responding is lost; X never reaches here since it masks detection.
  assign w_drop = w_detect & (r_state != IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_drop_cnt <= 8'd0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign DROP_CNT = r_drop_cnt;
`else
  assign DROP_CNT = 8'd0;
`endif

endmodule

// File: tb/tb_seq_responder.sv
// Directed bench for seq_responder with default parameters; checks J/K/BUSY per cycle and DROP_CNT.
module tb_seq_responder;

  logic       CLK;
  logic       RST;
  logic       C;
  logic       B;
  logic       A;
  logic       X;
  logic       J;
  logic       K;
  logic       BUSY;
  logic [7:0] DROP_CNT;

  int checks;
  int errors;

  seq_responder #(
    .JLEN(4),
    .BMAX(3)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .C       (C),
    .B       (B),
    .A       (A),
    .X       (X),
    .J       (J),
    .K       (K),
    .BUSY    (BUSY),
    .DROP_CNT(DROP_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

`ifdef SEQ_RESPONDER_DROP_CNT_EN
  localparam logic [7:0] DropAfterOverlap = 8'd1;
`else
  localparam logic [7:0] DropAfterOverlap = 8'd0;
`endif

  // Apply one cycle of inputs, then sample just after the edge that consumed them.
  task automatic run(input logic c, input logic b, input logic a, input logic x, input logic r);
    C = c; B = b; A = a; X = x; RST = r;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    run(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string tag, input logic ej, input logic ek, input logic eb);
    logic [2:0] obs;
    logic [2:0] exp;
    obs = {J, K, BUSY};
    exp = {ej, ek, eb};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s JKBUSY observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_drop(input string tag, input logic [7:0] exp);
    checks++;
    assert (DROP_CNT === exp) else begin
      errors++;
      $error("FAIL %s DROP_CNT observed=%0d expected=%0d", tag, DROP_CNT, exp);
    end
  endtask

  // Called right after the A edge: expects 4 J cycles, one K cycle, then quiet.
  task automatic expect_resp(input string tag);
    chk({tag, "_j1"}, 1'b1, 1'b0, 1'b1);
    for (int i = 2; i <= 4; i++) begin
      idle();
      chk($sformatf("%s_j%0d", tag, i), 1'b1, 1'b0, 1'b1);
    end
    idle();
    chk({tag, "_k"}, 1'b0, 1'b1, 1'b1);
    idle();
    chk({tag, "_end"}, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_quiet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_q%0d", tag, i), 1'b0, 1'b0, 1'b0);
      idle();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    C = 1'b0; B = 1'b0; A = 1'b0; X = 1'b0; RST = 1'b1;

    run(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset", 1'b0, 1'b0, 1'b0);
    chk_drop("reset_drop", 8'd0);
    idle();

    // C;B;A
    run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_resp("cba");

    // C;B;B;B;A (BMAX boundary)
    run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) run(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_resp("cb3a");

    // C;B;B;B;B;A exceeds BMAX
    run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) run(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_quiet("cb4a", 3);

    // C;BC;B;A matches two ways but is a single response
    run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_resp("overlap");
    chk_drop("overlap_drop", 8'd0);

    // C;B;A;C;B;A: second detection during RESP_J is dropped
    run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("dup_j1", 1'b1, 1'b0, 1'b1);
    run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("dup_j2", 1'b1, 1'b0, 1'b1);
    run(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("dup_j3", 1'b1, 1'b0, 1'b1);
    run(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("dup_j4", 1'b1, 1'b0, 1'b1);
    idle();
    chk("dup_k", 1'b0, 1'b1, 1'b1);
    idle();
    expect_quiet("dup", 3);
    chk_drop("dup_drop", DropAfterOverlap);

    // X in the 2nd J cycle aborts without K; DROP_CNT survives X
    run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("xab_j1", 1'b1, 1'b0, 1'b1);
    idle();
    chk("xab_j2", 1'b1, 1'b0, 1'b1);
    run(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_quiet("xab", 4);
    chk_drop("xab_drop", DropAfterOverlap);

    // C;B;X;A: X wipes history
    run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_quiet("cbxa", 3);

    // RST in the 3rd J cycle, then a fresh C;B;A
    run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("rst_j1", 1'b1, 1'b0, 1'b1);
    idle();
    chk("rst_j2", 1'b1, 1'b0, 1'b1);
    idle();
    chk("rst_j3", 1'b1, 1'b0, 1'b1);
    run(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_now", 1'b0, 1'b0, 1'b0);
    chk_drop("rst_drop", 8'd0);
    idle();
    expect_quiet("rst", 3);
    run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_resp("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_responder.md
SEQ_RESPONDER -- requirements
Module: seq_responder

Interface
REQ-001 The block SHALL take parameter JLEN, default 4, which is the number of consecutive J-high cycles in a response (legal range 1..15).
REQ-002 The block SHALL take parameter BMAX, default 3, which is the maximum consecutive B-high cycles accepted between C and A (legal range 1..7).
REQ-003 The block SHALL provide port CLK, input, 1 bit, the single clock; all state updates on posedge CLK.
REQ-004 The block SHALL provide port RST, input, 1 bit, a synchronous active-high reset.
REQ-005 The block SHALL provide ports C, B and A, each input, 1 bit, the enabling-sequence event strobes.
REQ-006 The block SHALL provide port X, input, 1 bit, an abort strobe.
REQ-007 The block SHALL provide port J, output, 1 bit, the response body strobe, registered.
REQ-008 The block SHALL provide port K, output, 1 bit, the response terminator strobe, registered.
REQ-009 The block SHALL provide port BUSY, output, 1 bit, which is high while a response (J or K phase) is in progress, registered.
REQ-010 The block SHALL provide port DROP_CNT, output, 8 bits, the count of detections dropped while busy.

Function
REQ-011 The block SHALL use a sampled history registering C over the last BMAX+1 cycles and B over the last BMAX cycles, cleared by RST or X.
REQ-012 The block SHALL declare a detection at sample cycle t when A(t)=1, X(t)=0, and some k in 1..BMAX has B(t-1..t-k) all 1 and C(t-k-1)=1.
REQ-013 Detection SHALL ignore B/C values coinciding with A, so that overlapping attempts are evaluated independently (e.g. C;BC;B;A matches via both k=1 and k=2, which counts as one detection).
REQ-014 The block SHALL implement FSM states IDLE, RESP_J and RESP_K.
REQ-015 IDLE->RESP_J SHALL occur on a detection; J=1 and BUSY=1 from the next cycle.
REQ-016 RESP_J SHALL hold for exactly JLEN cycles using a 4-bit down-counter loaded with JLEN-1, then transition to RESP_K.
REQ-017 RESP_K SHALL last one cycle with K=1 and J=0, then return to IDLE; J, K and BUSY become 0.
REQ-018 Resulting timing: with A sampled at edge t, J is high in cycles t+1..t+JLEN and K is high in cycle t+JLEN+1.
REQ-019 A detection occurring in RESP_J or RESP_K SHALL NOT restart or extend the response; it is dropped.
REQ-020 X=1 at any edge SHALL force IDLE, clear history and the counter, and drive J=K=BUSY=0 from the next cycle; X has priority over detection in the same cycle.
REQ-021 X SHALL NOT clear DROP_CNT.
REQ-022 J and K SHALL never be high in the same cycle.
REQ-023 Inputs sampled in the cycle after a response ends SHALL be eligible; history keeps updating during the response, so a sequence spanning the response end is detected.

Reset
REQ-024 RST=1 at posedge CLK SHALL set state IDLE and clear history, counter and DROP_CNT; J=K=BUSY=0 from the next cycle.
REQ-025 RST SHALL take priority over X and detection; RST mid-response SHALL abandon the response with no K.

Configuration
REQ-026 When macro SEQ_RESPONDER_DROP_CNT_EN is defined, DROP_CNT SHALL increment by 1 per dropped detection (REQ-019), saturating at 255, unaffected by X and cleared only by RST.
REQ-027 When SEQ_RESPONDER_DROP_CNT_EN is undefined, DROP_CNT SHALL be constant 0 and no counter logic SHALL be built; all other behaviour is identical.

Verification
REQ-028 The bench SHALL cover: C;B;A (one cycle each) with defaults -> J high 4 cycles starting the cycle after A, K high the 5th cycle, BUSY high 5 cycles.
REQ-029 The bench SHALL cover: C;B;B;B;A -> identical response; C;B;B;B;B;A -> no response (4 B exceeds BMAX=3).
REQ-030 The bench SHALL cover: C;B;A then X in the 2nd J cycle -> J drops in the following cycle, K never asserted, BUSY=0.
REQ-031 The bench SHALL cover: C;B;A;C;B;A (second A during RESP_J) with the macro defined -> a single 4J+K response and DROP_CNT=1; without the macro -> DROP_CNT=0.
REQ-032 The bench SHALL cover: C;B;X;A -> no response (X clears history).
REQ-033 The bench SHALL cover: RST asserted in the 3rd J cycle -> J=K=BUSY=0 from the next cycle and DROP_CNT=0; a following C;B;A produces a normal response.
